// File: rtl/cla_pkg.sv
// Shared types for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Width-independent part of the stage-1 payload; the wide p/g fields live in the top.
   typedef struct packed {
      logic cin;
      logic a_msb;
      logic b_msb;
   } s1_ctl_t;

endpackage

// File: rtl/cla_group.sv
// One lookahead group: flattened carries into every bit plus group propagate/generate.
// Purely combinational; reused for the second level by feeding it group P/G instead of bit p/g.
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] p,
   input  logic [GROUP-1:0] g,
   input  logic             cin,
   output logic [GROUP-1:0] c,
   output logic             gp,
   output logic             gg
);

   logic prod;

   always_comb begin
      c    = '0;
      gp   = 1'b1;
      gg   = 1'b0;
      prod = 1'b0;
      // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1:0]cin, each term a flat AND
      for (int i = 0; i < GROUP; i++) begin
         prod = cin;
         for (int j = 0; j < i; j++) prod = prod & p[j];
         c[i] = prod;
         for (int k = 0; k < i; k++) begin
            prod = g[k];
            for (int j = k + 1; j < i; j++) prod = prod & p[j];
            c[i] = c[i] | prod;
         end
      end
      for (int k = 0; k < GROUP; k++) begin
         prod = g[k];
         for (int j = k + 1; j < GROUP; j++) prod = prod & p[j];
         gg = gg | prod;
         gp = gp & p[k];
      end
   end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined CLA adder/subtractor with flags and valid/ready handshake.
// Stage 1 registers p/g and group P/G; stage 2 resolves carries and registers Sum and flags.
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_In,
   input  op_e              op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             C_Out,
   output logic             Ovf,
   output logic             Zero
);

   localparam int NGROUP = WIDTH / GROUP;

   generate
      if (WIDTH % GROUP != 0) begin : g_width_chk
         $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of GROUP");
      end
   endgenerate

   typedef struct packed {
      logic [WIDTH-1:0]  p;
      logic [WIDTH-1:0]  g;
      logic [NGROUP-1:0] gp;
      logic [NGROUP-1:0] gg;
      s1_ctl_t           ctl;
   } s1_t;

   logic             s1_valid;
   s1_t              s1;
   s1_t              s1_nxt;
   logic             adv1;
   logic             adv2;
   logic             accept;

   logic [WIDTH-1:0]  b_eff;
   logic [WIDTH-1:0]  p_in;
   logic [WIDTH-1:0]  g_in;
   logic [NGROUP-1:0] gp_in;
   logic [NGROUP-1:0] gg_in;
   logic [WIDTH-1:0]  s1_c_unused;

   logic [NGROUP-1:0] gcarry;
   logic              all_p;
   logic              all_g;
   logic [WIDTH-1:0]  bcarry;
   logic [NGROUP-1:0] s2_gp_unused;
   logic [NGROUP-1:0] s2_gg_unused;
   logic [WIDTH-1:0]  sum_nxt;
   logic              cout_nxt;
   logic              ovf_nxt;

   // Handshake: stage 1 may refill whenever it is empty or draining this cycle.
   assign adv2     = !out_valid || out_ready;
   assign adv1     = s1_valid && adv2;
   assign in_ready = !reset && (!s1_valid || adv2);
   assign accept   = in_valid && in_ready;

   // Stage 1: operand conditioning and per-group propagate/generate
   assign b_eff = (op == OP_SUB) ? ~B : B;
   assign p_in  = A ^ b_eff;
   assign g_in  = A & b_eff;

   for (genvar k = 0; k < NGROUP; k++) begin : g_s1_grp
      cla_group #(.GROUP(GROUP)) u_grp (
         .p   (p_in[k*GROUP +: GROUP]),
         .g   (g_in[k*GROUP +: GROUP]),
         .cin (1'b0),
         .c   (s1_c_unused[k*GROUP +: GROUP]),
         .gp  (gp_in[k]),
         .gg  (gg_in[k])
      );
   end

   always_comb begin
      s1_nxt           = '0;
      s1_nxt.p         = p_in;
      s1_nxt.g         = g_in;
      s1_nxt.gp        = gp_in;
      s1_nxt.gg        = gg_in;
      s1_nxt.ctl.cin   = (op == OP_SUB) ? 1'b1 : C_In;
      s1_nxt.ctl.a_msb = A[WIDTH-1];
      s1_nxt.ctl.b_msb = b_eff[WIDTH-1];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1       <= s1_nxt;
      end else if (adv1) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: second-level lookahead over groups, then in-group carries
   cla_group #(.GROUP(NGROUP)) u_lvl2 (
      .p   (s1.gp),
      .g   (s1.gg),
      .cin (s1.ctl.cin),
      .c   (gcarry),
      .gp  (all_p),
      .gg  (all_g)
   );

   for (genvar k = 0; k < NGROUP; k++) begin : g_s2_grp
      cla_group #(.GROUP(GROUP)) u_grp (
         .p   (s1.p[k*GROUP +: GROUP]),
         .g   (s1.g[k*GROUP +: GROUP]),
         .cin (gcarry[k]),
         .c   (bcarry[k*GROUP +: GROUP]),
         .gp  (s2_gp_unused[k]),
         .gg  (s2_gg_unused[k])
      );
   end

   assign sum_nxt  = s1.p ^ bcarry;
   assign cout_nxt = all_g | (all_p & s1.ctl.cin);
   assign ovf_nxt  = (s1.ctl.a_msb == s1.ctl.b_msb) && (sum_nxt[WIDTH-1] != s1.ctl.a_msb);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         Sum       <= '0;
         C_Out     <= 1'b0;
         Ovf       <= 1'b0;
         Zero      <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            Sum   <= sum_nxt;
            C_Out <= cout_nxt;
            Ovf   <= ovf_nxt;
            Zero  <= ~|sum_nxt;
         end
      end
   end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: a 16/4 instance for directed, streaming, stall and reset cases,
// and an 8/2 instance swept over every A,B pair against an integer-arithmetic model.
module tb_cla_adder_pipe;
   import cla_pkg::*;

   typedef struct {
      logic [63:0] res;
      int          acc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   always #5 clock = ~clock;

   logic        in_valid, in_ready, C_In, out_valid, out_ready, C_Out, Ovf, Zero;
   logic [15:0] A, B, Sum;
   op_e         op;

   logic        iv8, ir8, ci8, ov8, or8, co8, ovf8, z8;
   logic [7:0]  a8, b8, sum8;
   op_e         op8;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_out16 = 0;
   int          n_out8 = 0;
   int          first_out = 0;
   int          last_out = 0;
   bit          check_lat = 1'b0;
   exp_t        q16[$];
   exp_t        q8[$];
   exp_t        e16, e8;

   cla_adder_pipe #(.WIDTH(16), .GROUP(4)) u_dut16 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .C_In(C_In), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .C_Out(C_Out), .Ovf(Ovf), .Zero(Zero)
   );

   cla_adder_pipe #(.WIDTH(8), .GROUP(2)) u_dut8 (
      .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8),
      .A(a8), .B(b8), .C_In(ci8), .op(op8), .out_valid(ov8), .out_ready(or8),
      .Sum(sum8), .C_Out(co8), .Ovf(ovf8), .Zero(z8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Result packed as {ovf, zero, cout, sum}; overflow judged on true signed integer range.
   function automatic logic [63:0] model(input int w, input longint a, input longint b,
                                         input bit ci, input bit sub);
      longint mask = (longint'(1) << w) - 1;
      longint half = longint'(1) << (w - 1);
      longint bb   = sub ? (~b & mask) : b;
      longint c    = sub ? 1 : longint'(ci);
      longint tot  = a + bb + c;
      longint s    = tot & mask;
      longint co   = (tot >> w) & 1;
      longint sa   = (a >= half) ? a - (longint'(1) << w) : a;
      longint sb   = (bb >= half) ? bb - (longint'(1) << w) : bb;
      longint st   = sa + sb + c;
      bit     ov   = (st >= half) || (st < -half);
      return (64'(ov) << (w + 2)) | (64'(s == 0) << (w + 1)) | (64'(co) << w) | 64'(s);
   endfunction

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (out_valid && out_ready) begin
         if (n_out16 == 0) first_out = cyc;
         last_out = cyc;
         n_out16++;
         if (q16.size() == 0) check("spurious16", 1, 0);
         else begin
            e16 = q16.pop_front();
            check("beat16", 64'({Ovf, Zero, C_Out, Sum}), e16.res);
            if (check_lat) check("lat16", 64'(cyc - e16.acc), 2);
         end
      end
      if (in_valid && in_ready)
         q16.push_back('{model(16, longint'(A), longint'(B), C_In, op == OP_SUB), cyc});
      if (ov8 && or8) begin
         n_out8++;
         if (q8.size() == 0) check("spurious8", 1, 0);
         else begin
            e8 = q8.pop_front();
            check("beat8", 64'({ovf8, z8, co8, sum8}), e8.res);
         end
      end
      if (iv8 && ir8)
         q8.push_back('{model(8, longint'(a8), longint'(b8), ci8, op8 == OP_SUB), cyc});
   end

   task automatic resync();
      @(posedge clock);
      #1;
   endtask

   task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit ci, input bit sub);
      in_valid = 1'b1; A = a; B = b; C_In = ci; op = op_e'(sub);
      for (int t = 0; t < 200; t++) begin
         @(negedge clock);
         if (in_ready) begin
            resync();
            in_valid = 1'b0;
            return;
         end
      end
      check("send16_timeout", 1, 0);
      in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit ci, input bit sub);
      iv8 = 1'b1; a8 = a; b8 = b; ci8 = ci; op8 = op_e'(sub);
      for (int t = 0; t < 200; t++) begin
         @(negedge clock);
         if (ir8) begin
            resync();
            iv8 = 1'b0;
            return;
         end
      end
      check("send8_timeout", 1, 0);
      iv8 = 1'b0;
   endtask

   task automatic wait_out16();
      for (int t = 0; t < 20; t++) begin
         @(negedge clock);
         if (out_valid) return;
      end
      check("wait_out16_timeout", 1, 0);
   endtask

   initial begin
      int   acc;
      bit   have;
      bit   done;
      int   base;
      logic [15:0] held;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; C_In = 1'b0; op = OP_ADD;
      iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0; op8 = OP_ADD;
      repeat (3) resync();
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_sum", 64'(Sum), 0);
      check("rst_flags", 64'({C_Out, Ovf, Zero}), 0);
      check("rst_in_ready", 64'(in_ready), 0);
      reset = 1'b0;
      resync();
      check("post_rst_in_ready", 64'(in_ready), 1);

      check_lat = 1'b1;
      send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_out16();
      check("t1_sum", 64'(Sum), 64'h0000);
      check("t1_cout_zero_ovf", 64'({C_Out, Zero, Ovf}), 64'b110);
      resync();
      send16(16'h7FFF, 16'h0001, 1'b1, 1'b0);
      wait_out16();
      check("t2a_sum", 64'(Sum), 64'h8001);
      check("t2a_cout_ovf", 64'({C_Out, Ovf}), 64'b01);
      resync();
      send16(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_out16();
      check("t2b_sum", 64'(Sum), 64'h7FFF);
      check("t2b_cout_ovf", 64'({C_Out, Ovf}), 64'b11);
      resync();
      resync();

      n_out16 = 0;
      for (int i = 0; i < 100; i++)
         send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      repeat (5) resync();
      check("t3_count", 64'(n_out16), 100);
      check("t3_rate", 64'(last_out - first_out), 99);
      check("t3_drain", 64'(q16.size()), 0);
      check_lat = 1'b0;

      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++)
               send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            done = 1'b1;
         end
         begin
            while (!done) begin
               resync();
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      repeat (5) resync();
      check("rand_drain", 64'(q16.size()), 0);

      out_ready = 1'b0; in_valid = 1'b1;
      A = 16'($urandom); B = 16'($urandom); C_In = 1'($urandom); op = OP_ADD;
      acc = 0; have = 1'b0; held = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         if (in_ready) acc++;
         if (out_valid && !have) begin
            have = 1'b1;
            held = Sum;
         end
         resync();
         A = 16'($urandom); B = 16'($urandom);
      end
      check("t4_accepts", 64'(acc), 2);
      check("t4_in_ready", 64'(in_ready), 0);
      check("t4_out_seen", 64'(have), 1);
      check("t4_hold", 64'(Sum), 64'(held));
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) resync();
      check("t4_drain", 64'(q16.size()), 0);

      out_ready = 1'b0;
      send16(16'h1234, 16'h1111, 1'b0, 1'b0);
      send16(16'h4321, 16'h0101, 1'b1, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("t5_out_valid", 64'(out_valid), 0);
      check("t5_sum", 64'(Sum), 0);
      check("t5_in_ready", 64'(in_ready), 0);
      q16.delete();
      resync();
      reset = 1'b0; out_ready = 1'b1;
      base = n_out16;
      repeat (6) resync();
      check("t5_no_stale", 64'(n_out16 - base), 0);

      n_out8 = 0;
      for (int a = 0; a < 256; a++)
         for (int b = 0; b < 256; b++)
            send8(8'(a), 8'(b), 1'((a + b) & 1), 1'(((a + b) >> 1) & 1));
      repeat (5) resync();
      check("t6_count", 64'(n_out8), 65536);
      check("t6_drain", 64'(q8.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
